// File: rtl/afpm_io_sequencer.sv
// Byte-serial operand loader / result serializer for the log-approximate FP16 multiplier core.
// Optional WAIT-state watchdog is built only when AFPM_SEQ_TIMEOUT_EN is defined.
module afpm_io_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        in_valid,
  input  logic [7:0]  byte_a,
  input  logic [7:0]  byte_b,
  output logic        in_ready,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [15:0] mul_result,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HI,
    S_START,
    S_WAIT,
    S_OUT_LO,
    S_OUT_HI
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("afpm_io_sequencer: TIMEOUT must be in 1..255");
  end

  state_t      state_reg, state_next;
  logic [15:0] mul_a_reg, mul_a_next;
  logic [15:0] mul_b_reg, mul_b_next;
  logic [15:0] result_reg, result_next;
  logic        in_ready_reg, in_ready_next;
  logic        mul_start_reg, mul_start_next;
  logic [7:0]  out_byte_reg, out_byte_next;
  logic        out_valid_reg, out_valid_next;
  logic        busy_reg, busy_next;
  logic        overrun_reg, overrun_next;
  logic        accept;

`ifdef AFPM_SEQ_TIMEOUT_EN
  logic [7:0]  cnt_reg, cnt_next;
  logic        timeout_err_reg, timeout_err_next;
`endif

  // in_ready is registered, so acceptance is judged against what the source saw this cycle.
  assign accept = ena && in_valid && in_ready_reg;

  always_comb begin
    state_next   = state_reg;
    mul_a_next   = mul_a_reg;
    mul_b_next   = mul_b_reg;
    result_next  = result_reg;
    overrun_next = overrun_reg;
`ifdef AFPM_SEQ_TIMEOUT_EN
    cnt_next         = cnt_reg;
    timeout_err_next = timeout_err_reg;
`endif

    if (ena) begin
      if (in_valid && !in_ready_reg) begin
        overrun_next = 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            mul_a_next[7:0] = byte_a;
            mul_b_next[7:0] = byte_b;
            overrun_next    = 1'b0;
`ifdef AFPM_SEQ_TIMEOUT_EN
            timeout_err_next = 1'b0;
`endif
            state_next      = S_LOAD_HI;
          end
        end
        S_LOAD_HI: begin
          if (accept) begin
            mul_a_next[15:8] = byte_a;
            mul_b_next[15:8] = byte_b;
            state_next       = S_START;
          end
        end
        S_START: begin
`ifdef AFPM_SEQ_TIMEOUT_EN
          cnt_next = 8'd0;
`endif
          state_next = S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            result_next = mul_result;
            state_next  = S_OUT_LO;
          end
`ifdef AFPM_SEQ_TIMEOUT_EN
          // A done arriving on the expiry cycle takes priority over the qNaN substitute.
          else if (cnt_reg == 8'(TIMEOUT - 1)) begin
            result_next      = 16'h7E00;
            timeout_err_next = 1'b1;
            state_next       = S_OUT_LO;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
`endif
        end
        S_OUT_LO: state_next = S_OUT_HI;
        S_OUT_HI: state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they appear registered with the state.
    in_ready_next  = (state_next == S_IDLE) || (state_next == S_LOAD_HI);
    mul_start_next = (state_next == S_START);
    out_valid_next = (state_next == S_OUT_LO) || (state_next == S_OUT_HI);
    busy_next      = (state_next != S_IDLE);
    out_byte_next  = 8'h00;
    if (state_next == S_OUT_LO) begin
      out_byte_next = result_next[7:0];
    end else if (state_next == S_OUT_HI) begin
      out_byte_next = result_next[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      mul_a_reg     <= 16'h0000;
      mul_b_reg     <= 16'h0000;
      result_reg    <= 16'h0000;
      in_ready_reg  <= 1'b1;
      mul_start_reg <= 1'b0;
      out_byte_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mul_a_reg     <= mul_a_next;
      mul_b_reg     <= mul_b_next;
      result_reg    <= result_next;
      in_ready_reg  <= in_ready_next;
      mul_start_reg <= mul_start_next;
      out_byte_reg  <= out_byte_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
      overrun_reg   <= overrun_next;
    end
  end

`ifdef AFPM_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= 8'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready  = in_ready_reg;
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign mul_start = mul_start_reg;
  assign out_byte  = out_byte_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_afpm_io_sequencer.sv
// Directed bench for afpm_io_sequencer: a vector table for the basic frame plus
// hand sequences for gaps, overrun, ena stall, mid-frame reset and (optionally) the watchdog.
module tb_afpm_io_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic [7:0]  byte_a;
  logic [7:0]  byte_b;
  logic        in_ready;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_result;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // Stub core: done is high while the cycle count since start equals core_lat.
  int core_lat   = 1;
  bit core_never = 1'b0;
  int core_cnt   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_start) core_cnt <= 1;
    else if (core_cnt != 0 && core_cnt < 1000) core_cnt <= core_cnt + 1;
  end

  assign mul_done   = !core_never && (core_cnt == core_lat);
  assign mul_result = 16'h4400;

  afpm_io_sequencer #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_valid    (in_valid),
    .byte_a      (byte_a),
    .byte_b      (byte_b),
    .in_ready    (in_ready),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .mul_result  (mul_result),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
    logic       rdy;
    logic       st;
    logic       ov;
    logic [7:0] ob;
    logic       bsy;
    logic [15:0] ma;
    logic [15:0] mb;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    byte_a   = a;
    byte_b   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic frame 3E00 x 4200 with a 1-cycle core; each row is one clock edge.
    vecs[0] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 8'h3E, 8'h42, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h3E00, 16'h4200};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h3E00, 16'h4200};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 16'h3E00, 16'h4200};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 16'h3E00, 16'h4200};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h3E00, 16'h4200};

    rst_n = 1'b0;
    ena   = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("reset in_ready", 16'(in_ready), 16'h1);
    chk("reset busy", 16'(busy), 16'h0);
    chk("reset out_valid", 16'(out_valid), 16'h0);
    chk("reset mul_start", 16'(mul_start), 16'h0);
    chk("reset mul_a", mul_a, 16'h0000);
    chk("reset timeout_err", 16'(timeout_err), 16'h0);
    rst_n = 1'b1;
    $display("reset released");

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].vld, vecs[i].a, vecs[i].b);
      tick();
      $display("vec %0d: in_valid=%0b a=%h b=%h -> in_ready=%0b start=%0b out_valid=%0b out_byte=%h busy=%0b",
               i, vecs[i].vld, vecs[i].a, vecs[i].b, in_ready, mul_start, out_valid, out_byte, busy);
      chk($sformatf("vec%0d in_ready", i), 16'(in_ready), 16'(vecs[i].rdy));
      chk($sformatf("vec%0d mul_start", i), 16'(mul_start), 16'(vecs[i].st));
      chk($sformatf("vec%0d out_valid", i), 16'(out_valid), 16'(vecs[i].ov));
      chk($sformatf("vec%0d out_byte", i), 16'(out_byte), 16'(vecs[i].ob));
      chk($sformatf("vec%0d busy", i), 16'(busy), 16'(vecs[i].bsy));
      chk($sformatf("vec%0d mul_a", i), mul_a, vecs[i].ma);
      chk($sformatf("vec%0d mul_b", i), mul_b, vecs[i].mb);
      chk($sformatf("vec%0d overrun", i), 16'(overrun), 16'h0);
      chk($sformatf("vec%0d timeout_err", i), 16'(timeout_err), 16'h0);
    end

    // Gap of 3 cycles between bytes, 5-cycle core, stray byte during WAIT.
    core_lat = 5;
    drive(1'b1, 8'h00, 8'h00);
    tick();
    $display("gap frame: low byte sent");
    chk("gap low in_ready", 16'(in_ready), 16'h1);
    drive(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("gap idle%0d in_ready", i), 16'(in_ready), 16'h1);
      chk($sformatf("gap idle%0d mul_start", i), 16'(mul_start), 16'h0);
    end
    drive(1'b1, 8'h3E, 8'h42);
    tick();
    $display("gap frame: high byte sent, start=%0b", mul_start);
    chk("gap start", 16'(mul_start), 16'h1);
    chk("gap mul_a", mul_a, 16'h3E00);
    chk("gap mul_b", mul_b, 16'h4200);
    drive(1'b0, 8'h00, 8'h00);
    tick();
    chk("gap wait start low", 16'(mul_start), 16'h0);
    drive(1'b1, 8'h55, 8'h55);
    tick();
    $display("stray byte 55/55 in WAIT: overrun=%0b", overrun);
    chk("stray overrun", 16'(overrun), 16'h1);
    chk("stray mul_a", mul_a, 16'h3E00);
    chk("stray mul_b", mul_b, 16'h4200);
    drive(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lat5 wait%0d out_valid", i), 16'(out_valid), 16'h0);
    end
    tick();
    $display("lat5 result lo: valid=%0b byte=%h", out_valid, out_byte);
    chk("lat5 lo valid", 16'(out_valid), 16'h1);
    chk("lat5 lo byte", 16'(out_byte), 16'h00);
    tick();
    $display("lat5 result hi: valid=%0b byte=%h", out_valid, out_byte);
    chk("lat5 hi valid", 16'(out_valid), 16'h1);
    chk("lat5 hi byte", 16'(out_byte), 16'h44);
    tick();
    chk("lat5 idle in_ready", 16'(in_ready), 16'h1);
    chk("overrun sticky", 16'(overrun), 16'h1);
    drive(1'b1, 8'h00, 8'h00);
    tick();
    $display("new low byte: overrun=%0b", overrun);
    chk("overrun cleared", 16'(overrun), 16'h0);
    chk("new frame busy", 16'(busy), 16'h1);

    // ena held low for 4 cycles while the low result byte is presented.
    core_lat = 1;
    drive(1'b1, 8'h3E, 8'h42);
    tick();
    chk("stall start", 16'(mul_start), 16'h1);
    drive(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("stall lo byte", 16'(out_byte), 16'h00);
    chk("stall lo valid", 16'(out_valid), 16'h1);
    ena = 1'b0;
    drive(1'b1, 8'h55, 8'h55);
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("ena low cycle %0d: valid=%0b byte=%h", i, out_valid, out_byte);
      chk($sformatf("stall%0d valid", i), 16'(out_valid), 16'h1);
      chk($sformatf("stall%0d byte", i), 16'(out_byte), 16'h00);
      chk($sformatf("stall%0d overrun", i), 16'(overrun), 16'h0);
    end
    ena = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    tick();
    chk("stall hi byte", 16'(out_byte), 16'h44);
    chk("stall hi valid", 16'(out_valid), 16'h1);
    tick();
    chk("stall idle busy", 16'(busy), 16'h0);

    // Asynchronous reset during LOAD_HI discards the partial operand.
    drive(1'b1, 8'h11, 8'h22);
    tick();
    chk("partial mul_a", mul_a, 16'h3E11);
    drive(1'b0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset in LOAD_HI: busy=%0b mul_a=%h", busy, mul_a);
    chk("async rst busy", 16'(busy), 16'h0);
    chk("async rst in_ready", 16'(in_ready), 16'h1);
    chk("async rst mul_a", mul_a, 16'h0000);
    chk("async rst mul_b", mul_b, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h00, 8'h00);
    tick();
    drive(1'b1, 8'h3E, 8'h42);
    tick();
    chk("post rst mul_a", mul_a, 16'h3E00);
    chk("post rst mul_b", mul_b, 16'h4200);
    chk("post rst start", 16'(mul_start), 16'h1);
    drive(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("post rst lo byte", 16'(out_byte), 16'h00);
    chk("post rst lo valid", 16'(out_valid), 16'h1);
    tick();
    $display("post reset frame hi byte=%h", out_byte);
    chk("post rst hi byte", 16'(out_byte), 16'h44);
    tick();
    chk("post rst idle", 16'(busy), 16'h0);

`ifdef AFPM_SEQ_TIMEOUT_EN
    // Core never answers: after 4 WAIT cycles the qNaN is emitted.
    core_never = 1'b1;
    drive(1'b1, 8'h00, 8'h00);
    tick();
    drive(1'b1, 8'h3E, 8'h42);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("to wait%0d out_valid", i), 16'(out_valid), 16'h0);
    end
    tick();
    $display("timeout lo: valid=%0b byte=%h err=%0b", out_valid, out_byte, timeout_err);
    chk("to lo valid", 16'(out_valid), 16'h1);
    chk("to lo byte", 16'(out_byte), 16'h00);
    chk("to err", 16'(timeout_err), 16'h1);
    tick();
    chk("to hi byte", 16'(out_byte), 16'h7E);
    tick();
    chk("to err sticky", 16'(timeout_err), 16'h1);
    core_never = 1'b0;
    drive(1'b1, 8'h00, 8'h00);
    tick();
    chk("to err cleared", 16'(timeout_err), 16'h0);
    drive(1'b0, 8'h00, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afpm_io_sequencer.md
# afpm_io_sequencer

Byte-serial front/back-end controller for the logarithmic approximate FP16 multiplier core in `tt_um_logarithmic_afpm`.
- Collects two 16-bit operands, low byte first, over the 8-bit A and B input lanes.
- Issues a single start pulse to the multiplier core and waits for its done indication.
- Serializes the 16-bit product back out, low byte first.
- Sits between the top-level pin wrapper and the multiplier core, and is the only block that drives the core's operand and start inputs.

## Interface
- `TIMEOUT`, default 16: cycles `WAIT` tolerates before the watchdog fires (only with `AFPM_SEQ_TIMEOUT_EN`); legal range 1–255.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable; 0 freezes all state.
- `in_valid` in 1: operand byte strobe.
- `byte_a` in 8: operand A byte.
- `byte_b` in 8: operand B byte.
- `in_ready` out 1: byte is accepted this cycle if `in_valid && ena`.
- `mul_a` out 16: operand A to core.
- `mul_b` out 16: operand B to core.
- `mul_start` out 1: one-cycle start pulse to core.
- `mul_done` in 1: core result valid (pulse or level).
- `mul_result` in 16: core product.
- `out_byte` out 8: result byte.
- `out_valid` out 1: `out_byte` carries a result byte.
- `busy` out 1: high in every state except `IDLE`.
- `overrun` out 1: sticky; a byte arrived while `in_ready` = 0.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- All outputs are registered. Reset values: `in_ready` = 1; every other output = 0.
- States: `IDLE`, `LOAD_HI`, `START`, `WAIT`, `OUT_LO`, `OUT_HI`.
- `IDLE`: on an accepted byte, latch `byte_a`/`byte_b` into `mul_a[7:0]`/`mul_b[7:0]` → `LOAD_HI`. Accepting this byte also clears `overrun` and `timeout_err`.
- `LOAD_HI`: on an accepted byte, latch into `[15:8]` → `START`. Gaps are allowed between the two bytes; there is no timeout.
- `START`: `mul_start` = 1 for exactly this one cycle → `WAIT`.
- `WAIT`: first cycle with `mul_done` = 1 captures `mul_result` into the output register → `OUT_LO`. `mul_done` is ignored in every other state.
- `OUT_LO`: `out_byte` = result[7:0], `out_valid` = 1 → `OUT_HI`.
- `OUT_HI`: `out_byte` = result[15:8], `out_valid` = 1 → `IDLE`.
- `in_ready` = 1 only in `IDLE` and `LOAD_HI`.
- A byte with `in_valid` = 1 while `in_ready` = 0 (and `ena` = 1) is dropped and sets `overrun`. That byte is not counted as the low byte of a new frame.
- `mul_a`/`mul_b` hold from `START` until the next frame's low byte is latched.
- `ena` = 0: no transitions, no acceptance, no counter advance; all outputs hold. If a result byte is stalled this way, `out_valid` stays high. The sink must qualify `out_valid` with `ena`.
- Reset asserted mid-frame: all state and outputs return to reset values immediately; a partial operand is discarded.
- Sign, exponent and mantissa handling belong to the core. This block treats the bytes as opaque.

## Timing
- Low byte accepted at edge k, high byte at k+1 → `mul_start` high during cycle k+2, `WAIT` from k+3.
- `mul_done` seen at edge m → low result byte valid during cycle m+1, high byte during m+2. `IDLE` is reached at edge m+3, so a new low byte is accepted at m+3 at the earliest.
- With a 1-cycle core (done sampled at k+3): 6 cycles from the first accepted byte to the last result byte.
- Core contract: `mul_done` no earlier than the cycle after `mul_start`.

## Configuration
- `AFPM_SEQ_TIMEOUT_EN` defined:
  - An 8-bit counter runs in `WAIT`.
  - If `TIMEOUT` cycles pass without `mul_done`, load 16'h7E00 (FP16 qNaN) as the result, set `timeout_err` → `OUT_LO`.
  - If `mul_done` arrives on the same cycle the count expires, `mul_done` wins.
- Undefined: `WAIT` waits indefinitely; `timeout_err` is tied to 0 and no counter is built.

## Test plan
- Reset, then A = 16'h3E00, B = 16'h4200 (bytes 00/00 then 3E/42 on consecutive cycles), stub core returning 16'h4400 one cycle after start:
  - `mul_a` = 3E00, `mul_b` = 4200, one `mul_start` pulse;
  - `out_byte` 00 then 44 on consecutive `out_valid` cycles.
- Same frame with a 3-cycle gap between the low and high bytes, plus a 5-cycle core latency: identical outputs; `mul_start` 1 cycle after the high byte; output starts 1 cycle after done.
- Drive `in_valid` with byte 55/55 during `WAIT`: `overrun` = 1, operands unchanged. The next accepted low byte clears `overrun`.
- Pull `ena` low during `OUT_LO` for 4 cycles: `out_byte` = low byte held for all 4 cycles, `out_valid` high throughout; `OUT_HI` follows after `ena` returns.
- Assert `rst_n` = 0 in `LOAD_HI`: outputs go to reset values asynchronously; the next frame 3E00×4200 completes correctly.
- With `AFPM_SEQ_TIMEOUT_EN`, `TIMEOUT` = 4, core never asserts done: after 4 `WAIT` cycles, output bytes 00 then 7E and `timeout_err` = 1.
